// File: rtl/lcd_pixel_source.sv
// RGB565 raster source for the ST7789 SPI serializer: three vertical colour bars
// with a bouncing solid box, streamed one pixel per valid/ready transfer.
module lcd_pixel_source #(
  parameter int unsigned H_RES     = 240,
  parameter int unsigned V_RES     = 135,
  parameter int unsigned BOX_SIZE  = 16,
  parameter logic [15:0] BOX_COLOR = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        pix_ready,
  output logic        pix_valid,
  output logic [15:0] pix_data,
  output logic        pix_sof,
  output logic        pix_eol,
  output logic        pix_eof,
  output logic [15:0] frame_count
);

  localparam logic [7:0] X_LAST = 8'(H_RES - 1);
  localparam logic [7:0] Y_LAST = 8'(V_RES - 1);
  localparam logic [7:0] COL1   = 8'(H_RES / 3);
  localparam logic [7:0] COL2   = 8'(2 * H_RES / 3);
  localparam logic signed [9:0] BX_MAX = 10'(H_RES - BOX_SIZE);
  localparam logic signed [9:0] BY_MAX = 10'(V_RES - BOX_SIZE);
  localparam logic [8:0] BOX_W = 9'(BOX_SIZE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_FRAME_END
  } state_t;

  state_t      r_state;
  logic        r_valid;
  logic [7:0]  r_x;
  logic [7:0]  r_y;
  logic [7:0]  r_box_x;
  logic [7:0]  r_box_y;
  logic        r_dx_neg;
  logic        r_dy_neg;
  logic [15:0] r_frame_count;

  logic signed [9:0] w_nx;
  logic signed [9:0] w_ny;
  logic        w_dx_neg_next;
  logic        w_dy_neg_next;
  logic [7:0]  w_box_x_next;
  logic [7:0]  w_box_y_next;
  logic        w_in_box;
  logic [15:0] w_color;

  // Probe one step ahead with a sign bit; a bounce flips direction before the move.
  always_comb begin
    w_nx = $signed({2'b00, r_box_x}) + (r_dx_neg ? -10'sd1 : 10'sd1);
    w_ny = $signed({2'b00, r_box_y}) + (r_dy_neg ? -10'sd1 : 10'sd1);
    w_dx_neg_next = r_dx_neg ^ ((w_nx > BX_MAX) || (w_nx < 10'sd0));
    w_dy_neg_next = r_dy_neg ^ ((w_ny > BY_MAX) || (w_ny < 10'sd0));
    w_box_x_next  = r_box_x + (w_dx_neg_next ? 8'hFF : 8'h01);
    w_box_y_next  = r_box_y + (w_dy_neg_next ? 8'hFF : 8'h01);
  end

  always_comb begin
    w_in_box = (r_x >= r_box_x) && ({1'b0, r_x} < ({1'b0, r_box_x} + BOX_W)) &&
               (r_y >= r_box_y) && ({1'b0, r_y} < ({1'b0, r_box_y} + BOX_W));
    if (w_in_box)       w_color = BOX_COLOR;
    else if (r_x < COL1) w_color = 16'hF800;
    else if (r_x < COL2) w_color = 16'h07E0;
    else                 w_color = 16'h001F;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_valid       <= 1'b0;
      r_x           <= '0;
      r_y           <= '0;
      r_box_x       <= '0;
      r_box_y       <= '0;
      r_dx_neg      <= 1'b0;
      r_dy_neg      <= 1'b0;
      r_frame_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (enable) begin
            r_state <= S_STREAM;
            r_valid <= 1'b1;
          end
        end
        S_STREAM: begin
          if (pix_ready) begin
            if (r_x == X_LAST) begin
              r_x <= '0;
              if (r_y == Y_LAST) begin
                r_y     <= '0;
                r_state <= S_FRAME_END;
                r_valid <= 1'b0;
              end else begin
                r_y <= r_y + 8'd1;
              end
            end else begin
              r_x <= r_x + 8'd1;
            end
          end
        end
        S_FRAME_END: begin
          r_box_x       <= w_box_x_next;
          r_box_y       <= w_box_y_next;
          r_dx_neg      <= w_dx_neg_next;
          r_dy_neg      <= w_dy_neg_next;
          r_frame_count <= r_frame_count + 16'd1;
          if (enable) begin
            r_state <= S_STREAM;
            r_valid <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    pix_valid   = r_valid;
    pix_data    = r_valid ? w_color : '0;
    pix_sof     = r_valid && (r_x == '0) && (r_y == '0);
    pix_eol     = r_valid && (r_x == X_LAST);
    pix_eof     = r_valid && (r_x == X_LAST) && (r_y == Y_LAST);
    frame_count = r_frame_count;
  end

endmodule
